load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits directly upstream of the word-addressed data memory. Converts MIPS byte-addressed load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) from the MEM pipeline stage into word-indexed memory accesses.
- Sub-word stores are done as read-modify-write, because the memory writes whole words only.
- Checks alignment and returns sign- or zero-extended load data through a valid/ready handshake.

Parameters:
- MEM_DEPTH_LOG2, 8, log2 of memory depth in 32-bit words (256 words).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 illegal
- req_signed  in  1  load sign-extends when 1
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse for every accepted request
- rsp_rdata  out  32  extended load data; holds its value otherwise
- rsp_err  out  1  alignment or size error, valid with rsp_valid
- mem_read  out  1  memory read enable
- mem_write  out  1  memory write enable
- mem_addr  out  32  word index = zero-extended req_addr[MEM_DEPTH_LOG2+1:2]
- mem_wdata  out  32  full word to write
- mem_rdata  in  32  combinational read data; sampled only while mem_read=1

Behaviour:
- Reset (asynchronous, active-low): state IDLE; rsp_valid, rsp_err, mem_read, mem_write = 0; rsp_rdata, mem_wdata and internal latches = 0; req_ready = 1.
- Handshake:
  - A request is accepted on a rising edge with req_valid & req_ready.
  - The unit latches addr, size, signed flag and wdata at acceptance.
  - Requesters may hold req_valid; nothing else is accepted until the unit returns to IDLE.
- Lanes: little-endian; byte k = bits [8k+7:8k], k = addr[1:0]; half at addr[1] selects bits [15:0] or [31:16].
- Error: size 3, half with addr[0]=1, or word with addr[1:0]!=0.
  - Goes to ERR for one cycle with no memory access.
  - rsp_valid=1 and rsp_err=1 in the following cycle; rsp_rdata unchanged.
- States:
  - IDLE: req_ready=1. On accept:
    - error -> ERR
    - load -> LOAD
    - word store -> WR
    - byte/half store -> RMW_RD
  - LOAD: mem_read=1. On the edge, the extracted/extended lane is registered into rsp_rdata -> IDLE.
  - WR: mem_write=1, mem_wdata = latched wdata -> IDLE.
  - RMW_RD: mem_read=1. The edge captures mem_rdata merged with the new byte/half lane into the merge register -> RMW_WR.
  - RMW_WR: mem_write=1, mem_wdata = merge register; the other lanes are preserved bit-exact -> IDLE.
  - ERR: -> IDLE.
- Response timing: rsp_valid pulses in the cycle after the final access state, which is already IDLE. A new request may be accepted in that same cycle.
- Latency from accept edge to rsp_valid cycle:
  - load: 2 cycles
  - word store: 2 cycles
  - sub-word store: 3 cycles
  - error: 2 cycles
- Back-to-back throughput: one load every 2 cycles.
- Extension: LB/LH sign-extend bit 7/15 when req_signed=1, else zero-extend. Word loads ignore req_signed. Store data uses req_wdata[7:0] or [15:0].
- Address wrap: bits above MEM_DEPTH_LOG2+1 are dropped; byte 0x400 aliases word 0.
- Exclusivity: mem_read and mem_write are decoded from state and are never both high. No write occurs outside WR/RMW_WR.
- Reset mid-operation: reset during RMW_RD or RMW_RD->RMW_WR drops mem_write immediately; the memory word stays unmodified and no rsp_valid is issued.

Decomposition:
- lsu_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - the state enum (IDLE, LOAD, WR, RMW_RD, RMW_WR, ERR)
  - a function-free constant for the lane-select width
- One combinational sub-module, lsu_lane_align: load extract/extend and store merge given addr[1:0], size and signed flag. Shared by the LOAD and RMW_RD paths.

Test Plan:
- Memory word 50 = 0x00000007; LW addr 0xC8 -> rsp_valid 2 cycles after accept, rsp_rdata=0x00000007, rsp_err=0, exactly one mem_read cycle with mem_addr=50.
- Word 51 = 0x80FF7F01; LB 0xCD -> 0x0000007F; LB 0xCE -> 0xFFFFFFFF; LBU 0xCE -> 0x000000FF; LH 0xCE -> 0xFFFF80FF; LHU 0xCE -> 0x000080FF.
- Word 52 = 0x11223344; SB 0xD1 wdata 0xAA -> mem_write with 0x1122AA44, latency 3; then SH 0xD2 wdata 0xBEEF -> 0xBEEFAA44.
- LH 0x03, LW 0x02, size 3 at 0x00 -> rsp_valid with rsp_err=1 after 2 cycles; mem_read and mem_write never asserted.
- Assert rst_n low during RMW_RD of SB to 0xD0 -> no mem_write, word 52 unchanged, all outputs 0 and req_ready=1 during reset.
- req_valid held high with 4 consecutive LWs -> accepts on every second edge, each rsp_valid pulse lasts one cycle, no request dropped or duplicated.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and the
// width of the byte-lane selector.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int LANE_SEL_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WR,
    RMW_RD,
    RMW_WR,
    ERR
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: extracts and extends load data, and merges a byte/half
// store into the word read back from memory (little-endian lanes).
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [LANE_SEL_W-1:0] lane_off,
  input  logic [1:0]            size,
  input  logic                  is_signed,
  input  logic [31:0]           rdata,
  input  logic [15:0]           wdata,
  output logic [31:0]           load_data,
  output logic [31:0]           merged
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] wrep;

  always_comb begin
    byte_v = rdata[{lane_off, 3'b000} +: 8];
    half_v = lane_off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{is_signed & byte_v[7]}}, byte_v};
      SZ_HALF: load_data = {{16{is_signed & half_v[15]}}, half_v};
      default: load_data = rdata;
    endcase
    // Replicating the store data lets each lane pick its bits without a shifter.
    wrep = (size == SZ_BYTE) ? {4{wdata[7:0]}} : {2{wdata}};
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = gi;
    logic hit;
    assign hit = ((size == SZ_BYTE) && (lane_off == LANE)) ||
                 ((size == SZ_HALF) && (lane_off[1] == LANE[1]));
    assign merged[8*gi+7:8*gi] = hit ? wrep[8*gi+7:8*gi] : rdata[8*gi+7:8*gi];
  end

endmodule

// File: rtl/load_store_unit.sv
// MIPS byte-addressed load/store front end for a word-wide data memory.
// Sub-word stores are read-modify-write; misaligned or illegal requests error out.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int AW = MEM_DEPTH_LOG2 + 2;

  lsu_state_e  state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;

  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        unused_addr_hi;

  // Address bits above the memory depth alias onto the low words.
  assign unused_addr_hi = ^req_addr[31:AW];

  assign req_err = (req_size == 2'd3) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  lsu_lane_align u_align (
    .lane_off  (addr_q[LANE_SEL_W-1:0]),
    .size      (size_q),
    .is_signed (signed_q),
    .rdata     (mem_rdata),
    .wdata     (wdata_q[15:0]),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    signed_d    = signed_q;
    wdata_d     = wdata_q;
    merge_d     = merge_q;
    rdata_d     = rdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr[AW-1:0];
          size_d   = req_size;
          signed_d = req_signed;
          wdata_d  = req_wdata;
          if (req_err)                 state_d = ERR;
          else if (!req_write)         state_d = LOAD;
          else if (req_size == SZ_WORD) state_d = WR;
          else                         state_d = RMW_RD;
        end
      end
      LOAD: begin
        rdata_d     = load_data;
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      RMW_RD: begin
        merge_d = merged;
        state_d = RMW_WR;
      end
      RMW_WR: begin
        rsp_valid_d = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      wdata_q     <= '0;
      merge_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      wdata_q     <= wdata_d;
      merge_q     <= merge_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory strobes decode straight from state so reset kills them immediately.
  always_comb begin
    mem_wdata = '0;
    case (state_q)
      WR:      mem_wdata = wdata_q;
      RMW_WR:  mem_wdata = merge_q;
      default: mem_wdata = '0;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign mem_read  = (state_q == LOAD) || (state_q == RMW_RD);
  assign mem_write = (state_q == WR) || (state_q == RMW_WR);
  assign mem_addr  = {{(32 - MEM_DEPTH_LOG2){1'b0}}, addr_q[AW-1:2]};
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model and a response
// scoreboard checking data, error flag, latency and memory traffic.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:255];

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int nrd = 0;
  int nwr = 0;
  logic [31:0] acc_addr = '0;
  logic [31:0] wr_data = '0;

  load_store_unit #(.MEM_DEPTH_LOG2(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
  end

  function automatic void chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endfunction

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      nrd = 0;
      nwr = 0;
    end else begin
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk({e.tag, "_err"}, 32'(rsp_err), 32'(e.err));
          chk({e.tag, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.tag, "_lat"}, 32'(cyc - e.acc_cyc), 32'(e.lat));
          chk({e.tag, "_nrd"}, 32'(nrd), 32'(e.nrd));
          chk({e.tag, "_nwr"}, 32'(nwr), 32'(e.nwr));
          if (e.nrd + e.nwr > 0) chk({e.tag, "_maddr"}, acc_addr, e.addr);
          if (e.nwr > 0) chk({e.tag, "_wdata"}, wr_data, e.wdata);
          $display("rsp %-8s err=%0d rdata=%h lat=%0d rd=%0d wr=%0d",
                   e.tag, rsp_err, rsp_rdata, cyc - e.acc_cyc, nrd, nwr);
        end
        nrd = 0;
        nwr = 0;
      end
      if (mem_read || mem_write) begin
        chk("rw_exclusive", 32'(mem_read & mem_write), 32'd0);
        acc_addr = mem_addr;
        if (mem_read) nrd++;
        if (mem_write) begin
          nwr++;
          wr_data = mem_wdata;
        end
      end
    end
  end

  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] er, input logic ee, input int lat,
                        input int enrd, input int enwr, input logic [31:0] ea,
                        input logic [31:0] ewd);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    sb.push_back('{tag, er, ee, lat, enrd, enwr, ea, ewd, cyc});
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"},   32'(rsp_err),   32'd0);
    chk({tag, "_mem_read"},  32'(mem_read),  32'd0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    logic [31:0] b2b_addr [4];
    logic [31:0] b2b_data [4];
    int prev;
    int t;

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[50] = 32'h0000_0007;
    mem[51] = 32'h80FF_7F01;
    mem[52] = 32'h1122_3344;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // tag, wr, size, signed, addr, wdata, exp_rdata, exp_err, lat, nrd, nwr, exp_maddr, exp_wdata
    do_req("LW_C8",  1'b0, 2'd2, 1'b0, 32'hC8, 32'h0, 32'h0000_0007, 1'b0, 2, 1, 0, 32'd50, 32'h0);
    do_req("LB_CD",  1'b0, 2'd0, 1'b1, 32'hCD, 32'h0, 32'h0000_007F, 1'b0, 2, 1, 0, 32'd51, 32'h0);
    do_req("LB_CE",  1'b0, 2'd0, 1'b1, 32'hCE, 32'h0, 32'hFFFF_FFFF, 1'b0, 2, 1, 0, 32'd51, 32'h0);
    do_req("LBU_CE", 1'b0, 2'd0, 1'b0, 32'hCE, 32'h0, 32'h0000_00FF, 1'b0, 2, 1, 0, 32'd51, 32'h0);
    do_req("LH_CE",  1'b0, 2'd1, 1'b1, 32'hCE, 32'h0, 32'hFFFF_80FF, 1'b0, 2, 1, 0, 32'd51, 32'h0);
    do_req("LHU_CE", 1'b0, 2'd1, 1'b0, 32'hCE, 32'h0, 32'h0000_80FF, 1'b0, 2, 1, 0, 32'd51, 32'h0);
    do_req("LH_CC",  1'b0, 2'd1, 1'b1, 32'hCC, 32'h0, 32'h0000_7F01, 1'b0, 2, 1, 0, 32'd51, 32'h0);
    do_req("SB_D1",  1'b1, 2'd0, 1'b0, 32'hD1, 32'hFFFF_FFAA, 32'h0000_7F01, 1'b0, 3, 1, 1, 32'd52, 32'h1122_AA44);
    do_req("SH_D2",  1'b1, 2'd1, 1'b0, 32'hD2, 32'h1234_BEEF, 32'h0000_7F01, 1'b0, 3, 1, 1, 32'd52, 32'hBEEF_AA44);
    do_req("SW_4D4", 1'b1, 2'd2, 1'b0, 32'h4D4, 32'hCAFE_F00D, 32'h0000_7F01, 1'b0, 2, 0, 1, 32'd53, 32'hCAFE_F00D);
    do_req("LW_D4",  1'b0, 2'd2, 1'b1, 32'hD4, 32'h0, 32'hCAFE_F00D, 1'b0, 2, 1, 0, 32'd53, 32'h0);
    do_req("LH_03",  1'b0, 2'd1, 1'b1, 32'h03, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 0, 0, 32'd0, 32'h0);
    do_req("LW_02",  1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 0, 0, 32'd0, 32'h0);
    do_req("SZ3_00", 1'b0, 2'd3, 1'b0, 32'h00, 32'h0, 32'hCAFE_F00D, 1'b1, 2, 0, 0, 32'd0, 32'h0);
    drain();
    chk("mem52_after_rmw", mem[52], 32'hBEEF_AA44);
    chk("mem53_after_sw",  mem[53], 32'hCAFE_F00D);

    // Reset while the read half of a byte store is in flight.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size  = 2'd0;
    req_addr  = 32'hD0;
    req_wdata = 32'h0000_0055;
    chk("rst_rmw_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rst_rmw_in_rd", 32'(mem_read), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_rst");
    @(negedge clk);
    check_reset_outputs("mid_rst_hold");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mem52_after_rst", mem[52], 32'hBEEF_AA44);

    // Back-to-back loads with req_valid held high throughout.
    b2b_addr[0] = 32'hC8; b2b_data[0] = 32'h0000_0007;
    b2b_addr[1] = 32'hCC; b2b_data[1] = 32'h80FF_7F01;
    b2b_addr[2] = 32'hD0; b2b_data[2] = 32'hBEEF_AA44;
    b2b_addr[3] = 32'hD4; b2b_data[3] = 32'hCAFE_F00D;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (!req_ready && t < 10) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_ready", 32'(req_ready), 32'd1);
      req_addr = b2b_addr[i];
      sb.push_back('{"B2B_LW", b2b_data[i], 1'b0, 2, 1, 0, b2b_addr[i] >> 2, 32'h0, cyc});
      if (i > 0) chk("b2b_spacing", 32'(cyc - prev), 32'd2);
      prev = cyc;
      @(negedge clk);
    end
    req_valid = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("idle_no_rsp", 32'(rsp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
